pose_score_sequencer: RTL and testbench

POSE_SCORE_SEQUENCER -- requirements
Module: pose_score_sequencer

---
 rtl/pose_score_sequencer_if.sv | 81 ++++++++
 rtl/pose_score_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_pose_score_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pose_score_sequencer_if.sv
// Pose score sequencer bus: reference load, scorer load/query streams
// and the per-frame score result.
interface pose_score_sequencer_if #(
  parameter int HRES = 320,
  parameter int VRES = 180
) ();
  localparam int HWIDTH = $clog2(HRES);
  localparam int VWIDTH = $clog2(VRES);
  localparam int AWIDTH = $clog2(HRES * VRES);
  localparam int DWIDTH = $clog2(HRES + VRES + 1);
  localparam int SWIDTH = $clog2(HRES * VRES * (HRES + VRES) + 1);
  localparam int CWIDTH = $clog2(HRES * VRES + 1);

  logic              load_start_in;
  logic [AWIDTH-1:0] ref_addr_out;
  logic              ref_pixel_in;

  logic [HWIDTH-1:0] sc_pixel_hcount_out;
  logic [VWIDTH-1:0] sc_pixel_vcount_out;
  logic              sc_pixel_out;
  logic              sc_pixel_valid_out;

  logic [HWIDTH-1:0] cam_hcount_in;
  logic [VWIDTH-1:0] cam_vcount_in;
  logic              cam_pixel_in;
  logic              cam_valid_in;

  logic [HWIDTH-1:0] sc_hcount_out;
  logic [VWIDTH-1:0] sc_vcount_out;
  logic [DWIDTH-1:0] sc_distance_in;

  logic [SWIDTH-1:0] score_out;
  logic [CWIDTH-1:0] count_out;
  logic              score_valid_out;
  logic              ready_out;
  logic              busy_out;

  modport master (
    output load_start_in,
    input  ref_addr_out,
    output ref_pixel_in,
    input  sc_pixel_hcount_out,
    input  sc_pixel_vcount_out,
    input  sc_pixel_out,
    input  sc_pixel_valid_out,
    output cam_hcount_in,
    output cam_vcount_in,
    output cam_pixel_in,
    output cam_valid_in,
    input  sc_hcount_out,
    input  sc_vcount_out,
    output sc_distance_in,
    input  score_out,
    input  count_out,
    input  score_valid_out,
    input  ready_out,
    input  busy_out
  );

  modport slave (
    input  load_start_in,
    output ref_addr_out,
    input  ref_pixel_in,
    output sc_pixel_hcount_out,
    output sc_pixel_vcount_out,
    output sc_pixel_out,
    output sc_pixel_valid_out,
    input  cam_hcount_in,
    input  cam_vcount_in,
    input  cam_pixel_in,
    input  cam_valid_in,
    output sc_hcount_out,
    output sc_vcount_out,
    input  sc_distance_in,
    output score_out,
    output count_out,
    output score_valid_out,
    output ready_out,
    output busy_out
  );
endinterface

// File: rtl/pose_score_sequencer.sv
// Loads a reference skeleton into the distance scorer, then sums scorer
// distances over each camera frame's skeleton pixels.
module pose_score_sequencer #(
  parameter int HRES           = 320,
  parameter int VRES           = 180,
  parameter int REF_LATENCY    = 2,
  parameter int SCORER_LATENCY = 3,
  parameter int SETTLE_CYCLES  = HRES * VRES + 4
) (
  input  logic clk_in,
  input  logic rst_in,
  pose_score_sequencer_if.slave bus
);
  localparam int NPIX   = HRES * VRES;
  localparam int HWIDTH = $clog2(HRES);
  localparam int VWIDTH = $clog2(VRES);
  localparam int AWIDTH = $clog2(NPIX);
  localparam int SWIDTH = $clog2(NPIX * (HRES + VRES) + 1);
  localparam int CWIDTH = $clog2(NPIX + 1);
  localparam int TWIDTH = $clog2(SETTLE_CYCLES + 1);
  localparam int RL     = REF_LATENCY;
  localparam int SL     = SCORER_LATENCY;

  localparam logic [AWIDTH-1:0] ALAST = AWIDTH'(NPIX - 1);
  localparam logic [HWIDTH-1:0] HLAST = HWIDTH'(HRES - 1);
  localparam logic [VWIDTH-1:0] VLAST = VWIDTH'(VRES - 1);
  localparam logic [TWIDTH-1:0] TLAST = TWIDTH'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] READY  = 2'd3;

  logic [1:0]        state;
  logic [TWIDTH-1:0] settle_cnt;
  logic              start_load;
  logic              load_done;

  logic [AWIDTH-1:0] addr;
  logic [HWIDTH-1:0] addr_h;
  logic [VWIDTH-1:0] addr_v;
  logic              addr_act;

  logic              rp_ok [RL];
  logic [HWIDTH-1:0] rp_h  [RL];
  logic [VWIDTH-1:0] rp_v  [RL];

  logic              cam_ok;
  logic              cam_first;
  logic              cam_last;
  logic              cp_ok    [SL];
  logic              cp_px    [SL];
  logic              cp_first [SL];
  logic              cp_last  [SL];

  logic              d_ok;
  logic              d_first;
  logic              d_last;
  logic              hit;
  logic [SWIDTH-1:0] term;
  logic [CWIDTH-1:0] inc;
  logic [SWIDTH-1:0] acc;
  logic [CWIDTH-1:0] cnt;
  logic [SWIDTH-1:0] base_acc;
  logic [CWIDTH-1:0] base_cnt;
  logic              frame_open;
  logic [SWIDTH-1:0] score_q;
  logic [CWIDTH-1:0] count_q;
  logic              strobe_q;

  assign start_load = bus.load_start_in
                   && (state == IDLE || state == READY);

  assign load_done = rp_ok[RL-1]
                  && rp_h[RL-1] == HLAST
                  && rp_v[RL-1] == VLAST;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (start_load) state <= LOAD;
        end
        LOAD: begin
          if (load_done) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == TLAST) state <= READY;
          else settle_cnt <= settle_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster walk over the reference frame; h/v tracked alongside the address
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr     <= '0;
      addr_h   <= '0;
      addr_v   <= '0;
      addr_act <= 1'b0;
    end else if (start_load) begin
      addr     <= '0;
      addr_h   <= '0;
      addr_v   <= '0;
      addr_act <= 1'b1;
    end else if (addr_act) begin
      if (addr == ALAST) begin
        addr_act <= 1'b0;
      end else begin
        addr <= addr + 1'b1;
        if (addr_h == HLAST) begin
          addr_h <= '0;
          addr_v <= addr_v + 1'b1;
        end else begin
          addr_h <= addr_h + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RL; i++) begin
        rp_ok[i] <= 1'b0;
        rp_h[i]  <= '0;
        rp_v[i]  <= '0;
      end
    end else begin
      rp_ok[0] <= addr_act;
      rp_h[0]  <= addr_h;
      rp_v[0]  <= addr_v;
      for (int i = 1; i < RL; i++) begin
        rp_ok[i] <= rp_ok[i-1];
        rp_h[i]  <= rp_h[i-1];
        rp_v[i]  <= rp_v[i-1];
      end
    end
  end

  assign bus.ref_addr_out        = addr;
  assign bus.sc_pixel_valid_out  = rp_ok[RL-1];
  assign bus.sc_pixel_out        = rp_ok[RL-1] & bus.ref_pixel_in;
  assign bus.sc_pixel_hcount_out = rp_h[RL-1];
  assign bus.sc_pixel_vcount_out = rp_v[RL-1];

  assign bus.sc_hcount_out = rst_in ? '0 : bus.cam_hcount_in;
  assign bus.sc_vcount_out = rst_in ? '0 : bus.cam_vcount_in;

  assign cam_ok    = bus.cam_valid_in && state == READY;
  assign cam_first = cam_ok
                  && bus.cam_hcount_in == '0
                  && bus.cam_vcount_in == '0;
  assign cam_last  = cam_ok
                  && bus.cam_hcount_in == HLAST
                  && bus.cam_vcount_in == VLAST;

  // Camera flags ride alongside the scorer query to meet its distance
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < SL; i++) begin
        cp_ok[i]    <= 1'b0;
        cp_px[i]    <= 1'b0;
        cp_first[i] <= 1'b0;
        cp_last[i]  <= 1'b0;
      end
    end else begin
      cp_ok[0]    <= cam_ok && !start_load;
      cp_px[0]    <= bus.cam_pixel_in;
      cp_first[0] <= cam_first;
      cp_last[0]  <= cam_last;
      for (int i = 1; i < SL; i++) begin
        cp_ok[i]    <= cp_ok[i-1] && !start_load;
        cp_px[i]    <= cp_px[i-1];
        cp_first[i] <= cp_first[i-1];
        cp_last[i]  <= cp_last[i-1];
      end
    end
  end

  assign d_ok     = cp_ok[SL-1];
  assign d_first  = cp_first[SL-1];
  assign d_last   = cp_last[SL-1];
  assign hit      = d_ok && cp_px[SL-1];
  assign term     = hit ? SWIDTH'(bus.sc_distance_in) : '0;
  assign inc      = hit ? CWIDTH'(1) : '0;
  assign base_acc = d_first ? '0 : acc;
  assign base_cnt = d_first ? '0 : cnt;

  // A frame only reports if its first pixel was seen since the last clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc        <= '0;
      cnt        <= '0;
      frame_open <= 1'b0;
      score_q    <= '0;
      count_q    <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (start_load) begin
        acc        <= '0;
        cnt        <= '0;
        frame_open <= 1'b0;
      end else if (d_ok && d_last) begin
        if (frame_open || d_first) begin
          score_q  <= base_acc + term;
          count_q  <= base_cnt + inc;
          strobe_q <= 1'b1;
        end
        acc        <= '0;
        cnt        <= '0;
        frame_open <= 1'b0;
      end else if (d_ok) begin
        acc <= base_acc + term;
        cnt <= base_cnt + inc;
        if (d_first) frame_open <= 1'b1;
      end
    end
  end

  assign bus.score_out       = score_q;
  assign bus.count_out       = count_q;
  assign bus.score_valid_out = strobe_q;
  assign bus.ready_out       = state == READY;
  assign bus.busy_out        = state == LOAD || state == SETTLE;
endmodule

// File: tb/tb_pose_score_sequencer.sv
// Directed-sequence bench for pose_score_sequencer with a frame-level
// scoring model and latency models of the reference memory and scorer.
module tb_pose_score_sequencer;
  localparam int HRES = 4;
  localparam int VRES = 3;
  localparam int RL   = 2;
  localparam int SL   = 3;
  localparam int SC   = 16;
  localparam int N    = HRES * VRES;
  localparam int DMAX = HRES + VRES;
  localparam int HW   = $clog2(HRES);
  localparam int VW   = $clog2(VRES);
  localparam int DW   = $clog2(HRES + VRES + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pose_score_sequencer_if #(.HRES(HRES), .VRES(VRES)) bus ();

  pose_score_sequencer #(
    .HRES(HRES), .VRES(VRES), .REF_LATENCY(RL),
    .SCORER_LATENCY(SL), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  int ntests = 0;
  int nfail  = 0;

  bit refmem [N];
  bit pmap   [N];
  int dmem   [N];

  logic          rq [RL];
  logic [DW-1:0] sq [SL];
  int            env_idx;

  always @(posedge clk) begin
    rq[0] <= (int'(bus.ref_addr_out) < N) ? refmem[bus.ref_addr_out] : 1'b0;
    for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
    env_idx = int'(bus.sc_vcount_out) * HRES + int'(bus.sc_hcount_out);
    sq[0] <= (env_idx < N) ? DW'(dmem[env_idx]) : '0;
    for (int i = 1; i < SL; i++) sq[i] <= sq[i-1];
  end
  assign bus.ref_pixel_in   = rq[RL-1];
  assign bus.sc_distance_in = sq[SL-1];

  int cyc = 0;
  int nstrobe = 0;
  int s_cyc = 0;
  always @(posedge clk) begin
    cyc++;
    #2;
    if (bus.score_valid_out === 1'b1) begin
      nstrobe++;
      s_cyc = cyc;
    end
  end

  bit m_ready = 0;
  int exp_strobes = 0;
  int exp_score = 0;
  int exp_count = 0;
  int last_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic rand_frame();
    int k;
    for (int i = 0; i < N; i++) begin
      pmap[i] = 1'($urandom_range(1, 0));
      dmem[i] = $urandom_range(DMAX, 0);
    end
    k = $urandom_range(N - 1, 0);
    pmap[k] = 1'b1;
    dmem[k] = DMAX;
  endtask

  task automatic feed(input int from, input int to, input int gap_max);
    for (int i = from; i <= to; i++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      repeat (g) begin
        bus.cam_valid_in  = 1'b0;
        bus.cam_hcount_in = HW'($urandom_range(HRES - 1, 0));
        bus.cam_vcount_in = VW'($urandom_range(VRES - 1, 0));
        @(negedge clk);
      end
      bus.cam_hcount_in = HW'(i % HRES);
      bus.cam_vcount_in = VW'(i / HRES);
      bus.cam_pixel_in  = pmap[i];
      bus.cam_valid_in  = 1'b1;
      if (i == from) begin
        #1;
        check("query_h", bus.sc_hcount_out, i % HRES);
        check("query_v", bus.sc_vcount_out, i / HRES);
      end
      if (i == to) last_cyc = cyc;
      @(negedge clk);
    end
    bus.cam_valid_in = 1'b0;
    bus.cam_pixel_in = 1'b0;
    if (m_ready && from == 0 && to == N - 1) begin
      exp_strobes++;
      exp_score = 0;
      exp_count = 0;
      for (int i = 0; i < N; i++)
        if (pmap[i]) begin
          exp_score += dmem[i];
          exp_count++;
        end
    end
  endtask

  task automatic check_frame(input string tag, input bit expect_strobe);
    repeat (SL + 4) @(negedge clk);
    check({tag, "/strobes"}, nstrobe, exp_strobes);
    check({tag, "/score"}, bus.score_out, exp_score);
    check({tag, "/count"}, bus.count_out, exp_count);
    if (expect_strobe) check({tag, "/latency"}, s_cyc - last_cyc, SL + 1);
  endtask

  task automatic run_load(input int poke_at, input int rst_at);
    logic [63:0] hold_s;
    logic [63:0] hold_c;
    hold_s = 64'(bus.score_out);
    hold_c = 64'(bus.count_out);
    bus.load_start_in = 1'b1;
    @(negedge clk);
    bus.load_start_in = 1'b0;
    m_ready = 0;
    for (int t = 0; t < RL + N + SC + 2; t++) begin
      bit vld;
      int k;
      if (t == rst_at) begin
        bus.cam_hcount_in = HW'(HRES - 1);
        bus.cam_vcount_in = VW'(VRES - 1);
        rst = 1'b1;
        #1;
        check("rst/ready", bus.ready_out, 0);
        check("rst/busy", bus.busy_out, 0);
        check("rst/addr", bus.ref_addr_out, 0);
        check("rst/pvalid", bus.sc_pixel_valid_out, 0);
        check("rst/pixel", bus.sc_pixel_out, 0);
        check("rst/ph", bus.sc_pixel_hcount_out, 0);
        check("rst/pv", bus.sc_pixel_vcount_out, 0);
        check("rst/qh", bus.sc_hcount_out, 0);
        check("rst/qv", bus.sc_vcount_out, 0);
        check("rst/score", bus.score_out, 0);
        check("rst/count", bus.count_out, 0);
        check("rst/strobe", bus.score_valid_out, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_score = 0;
        exp_count = 0;
        repeat (RL + N + SC + 8) @(negedge clk);
        check("post_rst/ready", bus.ready_out, 0);
        check("post_rst/busy", bus.busy_out, 0);
        check("post_rst/pvalid", bus.sc_pixel_valid_out, 0);
        return;
      end
      vld = (t >= RL) && (t < RL + N);
      k = t - RL;
      if (t < N) check("load/addr", bus.ref_addr_out, t);
      check("load/pvalid", bus.sc_pixel_valid_out, vld);
      if (vld) begin
        check("load/pixel", bus.sc_pixel_out, refmem[k]);
        check("load/ph", bus.sc_pixel_hcount_out, k % HRES);
        check("load/pv", bus.sc_pixel_vcount_out, k / HRES);
      end
      check("load/busy", bus.busy_out, t < RL + N + SC);
      check("load/ready", bus.ready_out, t >= RL + N + SC);
      check("load/strobe", bus.score_valid_out, 0);
      check("load/score_hold", bus.score_out, hold_s);
      check("load/count_hold", bus.count_out, hold_c);
      bus.load_start_in = (t == poke_at);
      @(negedge clk);
    end
    bus.load_start_in = 1'b0;
    m_ready = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.load_start_in = 1'b0;
    bus.cam_hcount_in = '0;
    bus.cam_vcount_in = '0;
    bus.cam_pixel_in  = 1'b0;
    bus.cam_valid_in  = 1'b0;
    for (int i = 0; i < N; i++) begin
      refmem[i] = 1'b0;
      pmap[i]   = 1'b0;
      dmem[i]   = 0;
    end
    repeat (3) @(negedge clk);
    check("reset/ready", bus.ready_out, 0);
    check("reset/busy", bus.busy_out, 0);
    check("reset/addr", bus.ref_addr_out, 0);
    check("reset/pvalid", bus.sc_pixel_valid_out, 0);
    check("reset/strobe", bus.score_valid_out, 0);
    check("reset/score", bus.score_out, 0);
    check("reset/count", bus.count_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle/ready", bus.ready_out, 0);
    check("idle/busy", bus.busy_out, 0);

    rand_frame();
    feed(0, N - 1, 0);
    check_frame("idle_frame", 0);

    run_load(-1, -1);

    for (int i = 0; i < N; i++) begin
      pmap[i] = 1'b0;
      dmem[i] = $urandom_range(DMAX, 0);
    end
    pmap[2] = 1'b1;  dmem[2] = 1;
    pmap[6] = 1'b1;  dmem[6] = 2;
    pmap[11] = 1'b1; dmem[11] = 3;
    feed(0, N - 1, 0);
    check_frame("three_px", 1);

    for (int i = 0; i < N; i++) pmap[i] = 1'b0;
    feed(0, N - 1, 1);
    check_frame("empty", 1);

    rand_frame();
    feed(5, N - 1, 0);
    feed(0, N - 1, 1);
    check_frame("midstart", 1);

    for (int f = 0; f < 4; f++) begin
      rand_frame();
      feed(0, N - 1, 2);
      check_frame("random", 1);
    end

    for (int i = 0; i < N; i++) refmem[i] = 1'($urandom_range(1, 0));
    run_load(RL + N + 3, -1);
    rand_frame();
    feed(0, N - 1, 0);
    check_frame("after_poke", 1);

    rand_frame();
    feed(0, 6, 0);
    run_load(-1, -1);
    check_frame("abort", 0);
    rand_frame();
    feed(0, N - 1, 1);
    check_frame("after_abort", 1);

    run_load(-1, RL + 5);
    rand_frame();
    feed(0, N - 1, 0);
    check_frame("rst_idle_frame", 0);

    for (int i = 0; i < N; i++) refmem[i] = 1'($urandom_range(1, 0));
    run_load(-1, -1);
    rand_frame();
    feed(0, N - 1, 2);
    check_frame("recover", 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
